// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle add/sub/compare sequencer:
// default widths, op encoding and FSM state encoding.
package alu_pkg;

    localparam int ALU_DATA_W  = 32;
    localparam int ALU_SLICE_W = 8;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CMP  = 2'b10,
        OP_RSVD = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } alu_state_e;

endpackage

// File: rtl/byte_cla_slice.sv
// Combinational SLICE_W-bit carry-lookahead adder; the sequencer reuses one
// instance for every slice of the operand.
module byte_cla_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is the flattened sum-of-products of generate/propagate terms,
    // so no carry depends on a lower carry signal.
    always_comb begin
        logic term;
        logic acc;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            term = cin;
            for (int k = 0; k <= i; k++) term = term & prop[k];
            acc = term;
            for (int j = 0; j <= i; j++) begin
                term = gen[j];
                for (int k = j + 1; k <= i; k++) term = term & prop[k];
                acc = acc | term;
            end
            carry[i+1] = acc;
        end
    end

    assign sum  = prop ^ carry[SLICE_W-1:0];
    assign cout = carry[SLICE_W];

endmodule

// File: rtl/alu_addsub_seq.sv
// 32-bit ADD/SUB/CMP sequencer that walks one shared CLA slice across the
// operands, one slice per cycle, and owns the architectural Eq/Gt flags.
module alu_addsub_seq
    import alu_pkg::*;
#(
    parameter int DATA_W  = ALU_DATA_W,
    parameter int SLICE_W = ALU_SLICE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              eq_flag,
    output logic              gt_flag,
    output logic              busy
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    typedef logic [NUM_SLICES-1:0][SLICE_W-1:0] word_t;

    alu_state_e         state;
    alu_state_e         state_n;
    logic               accept;
    logic               last;
    logic [CNT_W-1:0]   cnt;
    word_t              a_l;
    word_t              b_l;
    word_t              result_work;
    word_t              result_final;
    alu_op_e            op_l;
    logic               carry_q;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               diff_zero;

    // Subtraction is a + ~b + 1; the +1 enters through the preloaded carry.
    assign slice_b = (op_l == OP_ADD) ? b_l[cnt] : ~b_l[cnt];

    byte_cla_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a   (a_l[cnt]),
        .b   (slice_b),
        .cin (carry_q),
        .sum (slice_sum),
        .cout(slice_cout)
    );

    always_comb begin
        result_final      = result_work;
        result_final[cnt] = slice_sum;
    end

    assign diff_zero = (result_final == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        last      = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = (alu_op_e'(op) == OP_RSVD) ? ST_RESP : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == CNT_W'(NUM_SLICES - 1)) begin
                    last    = 1'b1;
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand latch, per-slice accumulation, commit and response holding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_l         <= '0;
            b_l         <= '0;
            op_l        <= OP_ADD;
            carry_q     <= 1'b0;
            cnt         <= '0;
            result_work <= '0;
            result      <= '0;
            cout        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            eq_flag     <= 1'b0;
            gt_flag     <= 1'b0;
        end else begin
            if (accept) begin
                a_l     <= a;
                b_l     <= b;
                op_l    <= alu_op_e'(op);
                carry_q <= (alu_op_e'(op) == OP_SUB) || (alu_op_e'(op) == OP_CMP);
                cnt     <= '0;
                if (alu_op_e'(op) == OP_RSVD) begin
                    result    <= '0;
                    cout      <= 1'b0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                end
            end
            if (state == ST_CALC) begin
                result_work[cnt] <= slice_sum;
                carry_q          <= slice_cout;
                cnt              <= cnt + 1'b1;
                if (last) begin
                    result    <= result_final;
                    cout      <= slice_cout;
                    rsp_valid <= 1'b1;
                    if (op_l == OP_CMP) begin
                        eq_flag <= diff_zero;
                        gt_flag <= ~result_final[NUM_SLICES-1][SLICE_W-1] & ~diff_zero;
                    end
                end
            end
            if ((state == ST_RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Self-checking bench for alu_addsub_seq: directed corner cases followed by
// random ops, compared against a plain-arithmetic reference model.
module tb_alu_addsub_seq;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [31:0] result;
    logic        cout;
    logic        eq_flag;
    logic        gt_flag;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    logic model_eq = 1'b0;
    logic model_gt = 1'b0;

    alu_addsub_seq dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_err  (rsp_err),
        .result   (result),
        .cout     (cout),
        .eq_flag  (eq_flag),
        .gt_flag  (gt_flag),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge, let it be accepted, then scramble
    // the inputs so any use of unlatched operands shows up.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        req_valid = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        checkOutput("req_ready_before_accept", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        op        = 2'($urandom);
        a         = $urandom;
        b         = $urandom;
    endtask

    task automatic runOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int hold, input bit req_during_hold);
        logic [32:0] full;
        logic [31:0] exp_res;
        logic        exp_cout;
        int          exp_lat;
        int          lat;
        case (o)
            2'b00: begin
                full     = {1'b0, x} + {1'b0, y};
                exp_res  = full[31:0];
                exp_cout = full[32];
            end
            2'b01, 2'b10: begin
                exp_res  = x - y;
                exp_cout = (x >= y);
            end
            default: begin
                exp_res  = 32'h0;
                exp_cout = 1'b0;
            end
        endcase
        if (o == 2'b10) begin
            model_eq = (x == y);
            model_gt = !exp_res[31] && (x != y);
        end
        exp_lat = (o == 2'b11) ? 0 : 4;

        applyStimulus(o, x, y);
        checkOutput("busy_after_accept", busy, 1);
        checkOutput("req_ready_while_busy", req_ready, 0);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency_edges", lat, exp_lat);
        checkOutput("result", result, exp_res);
        checkOutput("cout", cout, exp_cout);
        checkOutput("rsp_err", rsp_err, (o == 2'b11));
        checkOutput("eq_flag", eq_flag, model_eq);
        checkOutput("gt_flag", gt_flag, model_gt);

        for (int i = 0; i < hold; i++) begin
            if (req_during_hold) begin
                req_valid = 1'b1;
                op        = 2'b00;
                a         = $urandom;
                b         = $urandom;
            end
            @(negedge clk);
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_result", result, exp_res);
            checkOutput("hold_cout", cout, exp_cout);
            checkOutput("hold_req_ready", req_ready, 0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_handshake", rsp_valid, 0);
        checkOutput("rsp_err_after_handshake", rsp_err, 0);
        checkOutput("result_retained", result, exp_res);
        checkOutput("cout_retained", cout, exp_cout);
        checkOutput("idle_after_handshake", busy, 0);
        checkOutput("req_ready_after_handshake", req_ready, 1);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        op        = 2'b00;
        a         = 32'h0;
        b         = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_cout", cout, 0);
        checkOutput("reset_eq", eq_flag, 0);
        checkOutput("reset_gt", gt_flag, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        runOp(2'b00, 32'h0000_00FF, 32'h0000_0001, 0, 1'b0);
        runOp(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
        runOp(2'b01, 32'd5, 32'd7, 0, 1'b0);
        runOp(2'b10, 32'd9, 32'd9, 0, 1'b0);
        runOp(2'b10, 32'd10, 32'd3, 0, 1'b0);
        runOp(2'b00, 32'd1, 32'd1, 0, 1'b0);

        // A second request waits behind a stalled response; it must only be
        // taken on the edge after the handshake, which the next runOp checks.
        runOp(2'b00, 32'h1234_0000, 32'h0000_5678, 3, 1'b1);
        runOp(2'b01, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);

        runOp(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0);

        runOp(2'b10, 32'd100, 32'd1, 0, 1'b0);
        applyStimulus(2'b00, 32'h1234_5678, 32'h1111_1111);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_eq = 1'b0;
        model_gt = 1'b0;
        checkOutput("midop_reset_rsp_valid", rsp_valid, 0);
        checkOutput("midop_reset_result", result, 0);
        checkOutput("midop_reset_eq", eq_flag, 0);
        checkOutput("midop_reset_gt", gt_flag, 0);
        checkOutput("midop_reset_busy", busy, 0);
        checkOutput("midop_reset_req_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("no_stale_response", rsp_valid, 0);
        end

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            runOp(r_op, r_a, r_b, $urandom_range(0, 2), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_addsub_seq.md
Name: alu_addsub_seq

Overview:
Multi-cycle sequencer that performs 32-bit ADD/SUB/CMP with one 8-bit carry-lookahead slice reused over 4 cycles. It trades latency for area in the simple RISC core.
Sits between decode/issue and writeback, using a valid/ready request and response handshake. It owns the architectural Eq/Gt compare flags.

Parameters:
DATA_W, 32, operand/result width; must be a multiple of SLICE_W
SLICE_W, 8, width of the shared CLA slice
NUM_SLICES, DATA_W/SLICE_W (derived, localparam), cycles per arithmetic op

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
op  in  2  00 ADD, 01 SUB, 10 CMP, 11 reserved
a  in  DATA_W  operand A
b  in  DATA_W  operand B
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_err  out  1  response is for a reserved op
result  out  DATA_W  sum/difference
cout  out  1  final carry-out (SUB/CMP: 1 = no borrow)
eq_flag  out  1  architectural Eq flag
gt_flag  out  1  architectural Gt flag
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-high.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, result 0, cout 0, eq_flag 0, gt_flag 0, busy 0, slice counter 0, carry register 0.
- FSM has three states: IDLE, CALC, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid at edge E0, latch a, b and op.
  - Carry register = 1 for SUB/CMP, 0 for ADD.
  - Slice counter = 0. Next state CALC; for op 11, next state RESP.
- CALC:
  - Each cycle, slice k computes a_l[k] + b_eff[k] + carry.
  - b_eff = ~b_l for SUB/CMP, b_l for ADD.
  - The sum byte is written into result_work[k]; the slice carry-out goes to the carry register; the counter increments.
  - After slice NUM_SLICES-1 (edge E4), commit:
    - result <= result_work (final byte included).
    - cout <= final carry.
    - rsp_valid <= 1. Next state RESP.
- Latency is exactly NUM_SLICES cycles: rsp_valid rises at E4 for accept at E0.
- Flags:
  - Updated only by CMP, at the commit edge.
  - eq_flag = (difference == 0).
  - gt_flag = ~difference[DATA_W-1] & ~eq.
  - The sign is taken directly from the difference, with no overflow correction (architectural decision).
  - ADD, SUB and reserved ops leave the flags unchanged.
- CMP also returns the difference on result and cout.
- Reserved op 11:
  - Goes from IDLE to RESP in one cycle.
  - result 0, cout 0, rsp_err 1, flags untouched.
- RESP:
  - rsp_valid held at 1; result, cout and rsp_err held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE and clear rsp_valid/rsp_err; result and cout retain their value.
  - No same-cycle request acceptance: minimum issue interval is NUM_SLICES+2 cycles.
- While busy:
  - req_ready = 0; req_valid is ignored.
  - Changes on a, b and op are ignored because operands are latched.
- Reset mid-CALC or mid-RESP: the transaction is dropped and all outputs return to their reset values on the next evaluation, with no partial result.
- Width rules: slice sum is SLICE_W+1 bits; the carry register is 1 bit; result_work is DATA_W bits, indexed by slice.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_RSVD=2'b11;
  - FSM state encoding ST_IDLE, ST_CALC, ST_RESP;
  - DATA_W/SLICE_W defaults.
- One sub-module, byte_cla_slice: combinational SLICE_W-bit carry-lookahead adder (A, B, Cin -> Sum, Cout), instantiated once.
- The FSM, counter, operand/carry registers and flag registers stay in alu_addsub_seq.

Test Plan:
- Inter-slice carry and overflow:
  - ADD a=0x000000FF, b=0x00000001 -> result 0x00000100, cout 0, rsp_valid exactly 4 cycles after accept.
  - ADD 0xFFFFFFFF + 1 -> result 0, cout 1.
- SUB borrow: SUB a=5, b=7 -> result 0xFFFFFFFE, cout 0; flags unchanged from reset (0/0).
- CMP then ADD:
  - CMP 9,9 -> eq 1, gt 0.
  - CMP 10,3 -> eq 0, gt 1, result 7.
  - Following ADD 1+1 -> result 2; eq/gt stay 0/1.
- Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> result, cout and rsp_valid stable; req_ready 0; a second req_valid is not accepted until the cycle after the handshake.
- Reset mid-op: assert reset during the 2nd CALC cycle -> immediate IDLE, rsp_valid 0, result 0, flags 0; no stale response afterwards.
- Reserved op: op=11 -> rsp_valid 1 cycle after accept, rsp_err 1, result 0, cout 0, flags unchanged.
